letter_slot_scheduler: RTL
==========================

# letter_slot_scheduler

Edit-and-commit controller for the three-character VGA letter display. Accepts one-command-at-a-time edit requests (write letter, backspace, clear) over a valid/ready handshake. Stages the result in shadow slot registers. Publishes the slots to the display controller's three 6-bit letter-select inputs only at a vertical-sync boundary, so a character never changes mid-frame. Sits between the keyboard/button decode logic and the VGA controller, in the 25 MHz pixel-clock domain.

## Interface
- BLANK_CODE, 6'h3F: slot value meaning "no character"; the display renders nothing.
- MAX_CODE, 6'd25: highest legal letter code. Codes are letter index: a=0, i=8, q=16, z=25.
- clk  in  1  pixel clock, same clock as the VGA controller.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  request present.
- key_op  in  2  00 write, 01 backspace, 10 clear, 11 no-op.
- key_code  in  6  letter code, used only for write.
- key_ready  out  1  block can accept a request; transfer occurs when key_valid & key_ready at a rising clk edge.
- v_sync  in  1  VGA vertical sync (active low, same clock domain).
- letter_sel_one / letter_sel_two / letter_sel_three  out  6 each  committed slot codes to the display.
- cursor  out  2  committed count of filled slots, 0..3.
- commit  out  1  one-cycle pulse, the cycle after the outputs update.
- err  out  1  one-cycle pulse on a rejected request.

## Operation
- Shadow slots sh[0..2] and shadow count cnt (0..3) hold the edits. The outputs are a separate committed copy.
- States:
  - IDLE: key_ready=1. On a transfer:
    - write, cnt<3, key_code<=MAX_CODE: go to APPLY.
    - write with cnt==3, or key_code>MAX_CODE: err pulse, stay IDLE.
    - backspace with cnt==0: err pulse, stay IDLE.
    - backspace with cnt>0: go to APPLY.
    - clear (any cnt): go to APPLY.
    - no-op: ignored, no err, stay IDLE.
  - APPLY (1 cycle, key_ready=0):
    - write: sh[cnt]<=latched code, cnt+1.
    - backspace: sh[cnt-1]<=BLANK_CODE, cnt-1.
    - clear: all sh<=BLANK_CODE, cnt<=0.
    - Then go to WAIT_VS.
  - WAIT_VS (key_ready=0): wait for a v_sync falling edge.
    - v_sync is registered into vs_q each cycle.
    - The edge condition is vs_prev=1 & vs_q=0.
    - On that cycle's edge, copy sh→letter_sel_*, cnt→cursor, and go to COMMIT.
  - COMMIT (1 cycle): commit=1, key_ready=0, then IDLE.
- key_op and key_code are latched on transfer. Later changes to the inputs have no effect.
- A v_sync falling edge that occurs while in IDLE or APPLY is not remembered. The commit waits for the next edge.
- Rejected requests never leave IDLE and never cause a commit.
- Reset value of every output and register:
  - letter_sel_* = BLANK_CODE, sh = BLANK_CODE.
  - cursor=0, cnt=0.
  - state=IDLE, so key_ready=1.
  - commit=0, err=0.
  - vs_q=1, vs_prev=1.
- Reset asserted mid-operation, in any state, returns to this reset condition immediately. Any pending edit is discarded.

## Timing
- Transfer sampled at edge N:
  - APPLY during cycle N→N+1.
  - Shadow updated at edge N+1.
  - WAIT_VS from N+1.
- v_sync goes low between edges M-1 and M: vs_q=0 after edge M, so the edge condition holds during cycle M→M+1. Commit happens at edge M+1.
  - letter_sel_*/cursor change at edge M+1.
  - commit is high during M+1→M+2.
  - key_ready returns high after edge M+2.
- err is high for exactly the cycle after the rejecting edge. key_ready stays 1 throughout.
- Throughput: at most one accepted edit per frame (800×525 = 420000 clocks).
- Worst-case latency from transfer to commit: one frame + 4 cycles.

## Test plan
- Reset, then write key_code=0 ('a') with v_sync pulsed low:
  - key_ready low from the cycle after transfer.
  - Outputs unchanged until the v_sync fall.
  - Then letter_sel_one=0, others 6'h3F, cursor=1, one commit pulse, key_ready back high.
- Writes of 0, 8, 16 with a frame between each: slots read 0/8/16 and cursor=3. A fourth write of 2 gives err pulse, no commit, slots unchanged.
- From 0/8/16: backspace gives slots 0/8/3F, cursor=2. Clear gives all 3F, cursor=0. Backspace at cursor=0 gives err only.
- Write with key_code=30: err pulse, no state change, key_ready stays 1.
- v_sync falling in the same cycle as the transfer (edge lands during APPLY): no commit on that edge. Commit occurs on the next v_sync fall.
- Assert rst_n low while in WAIT_VS with a pending write: all outputs return to reset values asynchronously, and no commit appears after release.

Source files
------------

// File: rtl/letter_slot_scheduler.sv
// Edit-and-commit controller for the three-slot letter display: edits land in
// shadow slots and are published to the display only on a v_sync falling edge.
module letter_slot_scheduler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [1:0] key_op,
  input  logic [5:0] key_code,
  output logic       key_ready,
  input  logic       v_sync,
  output logic [5:0] letter_sel_one,
  output logic [5:0] letter_sel_two,
  output logic [5:0] letter_sel_three,
  output logic [1:0] cursor,
  output logic       commit,
  output logic       err
);

  localparam logic [5:0] BLANK_CODE = 6'h3F;
  localparam logic [5:0] MAX_CODE   = 6'd25;

  typedef enum logic [1:0] {IDLE, APPLY, WAIT_VS, COMMIT} state_e;
  typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_BKSP = 2'b01,
                            OP_CLEAR = 2'b10, OP_NOP  = 2'b11} op_e;

  state_e     state_q, state_d;
  op_e        op_q;
  logic [5:0] code_q;
  logic [5:0] sh_q [3];
  logic [5:0] sh_d [3];
  logic [1:0] cnt_q, cnt_d;
  logic [5:0] sel_q [3];
  logic [1:0] cursor_q;
  logic       err_q;
  logic       vs_q, vs_prev_q;

  logic       xfer, accept, reject, vs_fall;
  logic [1:0] bksp_idx;

  assign xfer    = key_valid & key_ready;
  assign vs_fall = vs_prev_q & ~vs_q;

  // Request classification; only meaningful while IDLE (key_ready gates xfer).
  always_comb begin
    accept = 1'b0;
    reject = 1'b0;
    if (xfer) begin
      unique case (op_e'(key_op))
        OP_WRITE: begin
          if (cnt_q == 2'd3 || key_code > MAX_CODE) reject = 1'b1;
          else                                      accept = 1'b1;
        end
        OP_BKSP: begin
          if (cnt_q == 2'd0) reject = 1'b1;
          else               accept = 1'b1;
        end
        OP_CLEAR: accept = 1'b1;
        OP_NOP:   ;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = APPLY;
      APPLY:   state_d = WAIT_VS;
      WAIT_VS: if (vs_fall) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    key_ready = (state_q == IDLE);
    commit    = (state_q == COMMIT);
  end

  assign bksp_idx = cnt_q - 2'd1;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (state_q == APPLY) begin
      unique case (op_q)
        OP_WRITE: begin
          sh_d[cnt_q] = code_q;
          cnt_d       = cnt_q + 2'd1;
        end
        OP_BKSP: begin
          sh_d[bksp_idx] = BLANK_CODE;
          cnt_d          = bksp_idx;
        end
        OP_CLEAR: begin
          for (int unsigned i = 0; i < 3; i++) sh_d[i] = BLANK_CODE;
          cnt_d = '0;
        end
        OP_NOP: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_NOP;
      code_q    <= '0;
      cnt_q     <= '0;
      cursor_q  <= '0;
      err_q     <= 1'b0;
      vs_q      <= 1'b1;
      vs_prev_q <= 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
        sh_q[i]  <= BLANK_CODE;
        sel_q[i] <= BLANK_CODE;
      end
    end else begin
      vs_q      <= v_sync;
      vs_prev_q <= vs_q;
      err_q     <= reject;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      if (accept) begin
        op_q   <= op_e'(key_op);
        code_q <= key_code;
      end
      // Edges seen outside WAIT_VS are deliberately dropped.
      if (state_q == WAIT_VS && vs_fall) begin
        sel_q    <= sh_q;
        cursor_q <= cnt_q;
      end
    end
  end

  assign letter_sel_one   = sel_q[0];
  assign letter_sel_two   = sel_q[1];
  assign letter_sel_three = sel_q[2];
  assign cursor           = cursor_q;
  assign err              = err_q;

endmodule
